nor_bank: RTL and testbench
===========================

NOR_BANK -- requirements
Module: nor_bank

Interface
REQ-001 The parameters SHALL be, one per line:
- CHANNELS, 4, number of independent NOR gates.
- FANIN, 3, inputs per gate.
- IV, {CHANNELS{1'b0}}, per-channel initial/reset output value.
- DELAY, 1, inertial delay in SIM_CLK cycles; legal range 1..15.
- IN_MASK, all ones (CHANNELS*FANIN bits), 1 = input connected, 0 = input ignored.
REQ-002 The ports SHALL be, one per line:
- SIM_CLK  input  1  simulation clock; both edges are used.
- SIM_RST  input  1  reset, synchronous, active-high, sampled at posedge SIM_CLK.
- a  input  CHANNELS*FANIN  gate inputs; channel c uses a[c*FANIN +: FANIN].
- y  output  CHANNELS  registered gate outputs.
- busy  output  CHANNELS  per-channel transition pending.
- osc  output  CHANNELS  per-channel sticky ring-suppression flag.
REQ-003 The block SHALL have one clock, SIM_CLK, and a synchronous, active-high reset, SIM_RST.

Function
REQ-004 The combinational value for each channel SHALL be res_c = ~|(a_c & IN_MASK_c); a channel with all inputs masked SHALL have res_c = 1.
REQ-005 At each negedge, each channel SHALL compute a candidate:
- cand_c = IV_c when res_c == prev_c, y_c == IV_c and res_c != IV_c (ring suppression).
- cand_c = res_c otherwise.
REQ-006 At the same negedge, osc_c SHALL be set when the suppression term of REQ-005 selects IV_c; osc_c SHALL stay set until reset.
REQ-007 At each posedge, prev_c SHALL load the pre-edge value of y_c.
REQ-008 Each channel SHALL hold a 4-bit counter cnt_c, updated at each posedge:
- if cand_c == y_c: cnt_c <= 0.
- else if cnt_c == DELAY-1: y_c <= cand_c and cnt_c <= 0.
- else: cnt_c <= cnt_c + 1.
REQ-009 As a result of REQ-008, y_c SHALL change only after cand_c has differed from y_c at DELAY consecutive posedges; a shorter disagreement SHALL be discarded without affecting y_c.
REQ-010 With DELAY = 1, y_c SHALL follow cand_c at the first posedge after the negedge that computed it (single-gate legacy timing).
REQ-011 busy_c SHALL equal (cnt_c != 0).
REQ-012 Channels SHALL be fully independent; no state SHALL be shared between channels.
REQ-013 A DELAY outside 1..15 SHALL be treated as an elaboration error, for example via a generate-time $error.

Reset
REQ-014 At a posedge with SIM_RST = 1, the block SHALL load:
- y <= IV and prev <= IV.
- cnt <= 0, so busy = 0.
- osc <= 0.
REQ-015 At a negedge with SIM_RST = 1, the block SHALL force cand_c = IV_c and SHALL NOT set osc.
REQ-016 At time zero, before any reset, all registers SHALL hold the values listed in REQ-014.
REQ-017 Reset asserted while cnt_c != 0 SHALL abort the pending transition; y_c SHALL stay at IV_c.
REQ-018 After SIM_RST deasserts, the first update SHALL be a negedge computation followed by a posedge commit.

Verification
REQ-019 Legacy timing check (CHANNELS=1, FANIN=2, DELAY=1, IV=0): a = 2'b00 -> y = 1 at the first posedge after the next negedge; a = 2'b01 -> y = 0 one cycle later.
REQ-020 Inertial delay check (DELAY=3, IV=0, y=0, a driving res = 1):
- res = 1 for 2 cycles, then 0 -> y stays 0, busy pulses for 2 cycles.
- res = 1 for 3 cycles -> y = 1 at the third posedge, busy = 0 afterwards.
REQ-021 Mask check (FANIN=3, IN_MASK channel 0 = 3'b001): a_0 = 3'b110 -> y_0 = 1; a_0 = 3'b001 -> y_0 = 0.
REQ-022 Ring suppression check (DELAY=1, IV=0): drive res_c alternating 1,0,1 on successive cycles -> the second rise is suppressed, y_c stays 0, osc_c = 1 and stays 1 until SIM_RST.
REQ-023 Reset check, part 1 (DELAY=4, IV=4'b1010): assert SIM_RST for one posedge while cnt_c = 2 -> y = 4'b1010, busy = 0, osc = 0 at that posedge.
REQ-024 Reset check, part 2 (same setup as REQ-023): after deassertion, a 3-cycle input pulse produces no change on y.

Source files
------------

// File: rtl/nor_bank.sv
// Bank of independent NOR gates with per-channel inertial delay and ring suppression.
// Candidates are computed on the falling edge and committed on the rising edge.
module nor_bank #(
  parameter int unsigned               CHANNELS = 4,
  parameter int unsigned               FANIN    = 3,
  parameter logic [CHANNELS-1:0]       IV       = {CHANNELS{1'b0}},
  parameter int unsigned               DELAY    = 1,
  parameter logic [CHANNELS*FANIN-1:0] IN_MASK  = {(CHANNELS*FANIN){1'b1}}
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic [CHANNELS*FANIN-1:0] a,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       osc
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  if ((DELAY < 1) || (DELAY > 15)) begin : g_bad_delay
    $error("nor_bank: DELAY must be in 1..15");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             res;
    logic             sup;
    logic             cand  = IV[c];
    logic             prev  = IV[c];
    logic             y_q   = IV[c];
    logic [CNT_W-1:0] cnt   = '0;
    // osc is the XOR of a falling-edge toggle and a rising-edge snapshot, so the
    // falling edge can set it while the rising-edge reset clears it without a shared driver.
    logic             osc_n = 1'b0;
    logic             osc_p = 1'b0;

    assign res = ~|(a[c*FANIN +: FANIN] & IN_MASK[c*FANIN +: FANIN]);

    // Output just fell back to IV and the gate wants to leave it again: a ring.
    assign sup = (res == prev) && (y_q == IV[c]) && (res != IV[c]);

    // Falling edge: candidate and sticky suppression flag.
    always_ff @(negedge SIM_CLK) begin
      if (SIM_RST) begin
        cand <= IV[c];
      end else begin
        cand <= sup ? IV[c] : res;
        if (sup && (osc_n == osc_p)) begin
          osc_n <= ~osc_n;
        end
      end
    end

    // Rising edge: inertial filter and commit.
    always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
        y_q   <= IV[c];
        prev  <= IV[c];
        cnt   <= '0;
        osc_p <= osc_n;
      end else begin
        prev <= y_q;
        if (cand == y_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          y_q <= cand;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign y[c]    = y_q;
    assign busy[c] = (cnt != '0);
    assign osc[c]  = osc_n ^ osc_p;
  end

endmodule

// File: tb/tb_nor_bank.sv
// Directed bench for nor_bank: legacy timing, mask/NOR table, ring suppression,
// inertial filtering and reset abort, across four parameterisations.
module tb_nor_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  a_leg;
  logic [0:0]  y_leg, busy_leg, osc_leg;
  logic [11:0] a_main;
  logic [3:0]  y_main, busy_main, osc_main;
  logic [2:0]  a_inr;
  logic [0:0]  y_inr, busy_inr, osc_inr;
  logic [11:0] a_rst;
  logic [3:0]  y_rst, busy_rst, osc_rst;

  nor_bank #(.CHANNELS(1), .FANIN(2), .IV(1'b0), .DELAY(1), .IN_MASK(2'b11)) u_leg (
    .SIM_CLK(clk), .SIM_RST(rst), .a(a_leg), .y(y_leg), .busy(busy_leg), .osc(osc_leg));

  nor_bank #(.CHANNELS(4), .FANIN(3), .IV(4'b0000), .DELAY(1),
             .IN_MASK(12'b111_111_111_001)) u_main (
    .SIM_CLK(clk), .SIM_RST(rst), .a(a_main), .y(y_main), .busy(busy_main), .osc(osc_main));

  nor_bank #(.CHANNELS(1), .FANIN(3), .IV(1'b0), .DELAY(3), .IN_MASK(3'b111)) u_inr (
    .SIM_CLK(clk), .SIM_RST(rst), .a(a_inr), .y(y_inr), .busy(busy_inr), .osc(osc_inr));

  nor_bank #(.CHANNELS(4), .FANIN(3), .IV(4'b1010), .DELAY(4),
             .IN_MASK(12'hFFF)) u_rst (
    .SIM_CLK(clk), .SIM_RST(rst), .a(a_rst), .y(y_rst), .busy(busy_rst), .osc(osc_rst));

  typedef struct packed {
    logic [11:0] a;
    logic [3:0]  y;
  } vec_t;

  localparam logic [11:0] RST_STEADY = 12'b000_111_000_111;
  localparam logic [11:0] RST_FLIP   = 12'b111_000_111_000;
  localparam logic [11:0] CH1_HIGH   = 12'b111_111_000_111;

  int checks = 0;
  int errors = 0;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Channel 0 only sees bit 0; channels 1..3 are plain 3-input NORs.
    vecs[0] = '{a: 12'b000_000_000_000, y: 4'b1111};
    vecs[1] = '{a: 12'b001_010_100_110, y: 4'b0001};
    vecs[2] = '{a: 12'b000_000_000_001, y: 4'b1110};
    vecs[3] = '{a: 12'b111_000_111_000, y: 4'b0101};
    vecs[4] = '{a: 12'b000_111_000_111, y: 4'b1010};
    vecs[5] = '{a: 12'b100_000_000_110, y: 4'b0111};

    rst    = 1'b1;
    a_leg  = 2'b11;
    a_main = 12'hFFF;
    a_inr  = 3'b111;
    a_rst  = RST_STEADY;

    // Power-up values before any clock edge
    #1;
    chk("t0_y_leg",   16'(y_leg),    16'h0);
    chk("t0_y_main",  16'(y_main),   16'h0);
    chk("t0_y_rst",   16'(y_rst),    16'ha);
    chk("t0_busy_rst",16'(busy_rst), 16'h0);
    chk("t0_osc_rst", 16'(osc_rst),  16'h0);
    tick;
    tick;
    chk("rst_y_rst", 16'(y_rst), 16'ha);
    rst = 1'b0;

    // Legacy single-gate timing
    tick;
    tick;
    chk("leg_idle", 16'(y_leg), 16'h0);
    a_leg = 2'b00;
    @(negedge clk);
    #1;
    chk("leg_pre_commit", 16'(y_leg), 16'h0);
    tick;
    chk("leg_rise", 16'(y_leg), 16'h1);
    a_leg = 2'b01;
    tick;
    chk("leg_fall", 16'(y_leg), 16'h0);

    // NOR / mask table, each vector held two cycles
    for (int i = 0; i < 6; i++) begin
      a_main = vecs[i].a;
      tick;
      tick;
      chk($sformatf("vec%0d_y", i),    16'(y_main),    16'(vecs[i].y));
      chk($sformatf("vec%0d_busy", i), 16'(busy_main), 16'h0);
      chk($sformatf("vec%0d_osc", i),  16'(osc_main),  16'h0);
    end

    // Ring suppression on channel 1: res 1,0,1
    a_main = 12'hFFF;
    tick;
    tick;
    chk("ring_idle", 16'(y_main), 16'h0);
    a_main = CH1_HIGH;
    tick;
    chk("ring_rise1", 16'(y_main), 16'h2);
    a_main = 12'hFFF;
    tick;
    chk("ring_fall", 16'(y_main), 16'h0);
    a_main = CH1_HIGH;
    tick;
    chk("ring_supp_y",   16'(y_main),   16'h0);
    chk("ring_supp_osc", 16'(osc_main), 16'h2);
    tick;
    chk("ring_after_y",   16'(y_main),   16'h2);
    chk("ring_after_osc", 16'(osc_main), 16'h2);
    a_main = 12'hFFF;
    tick;
    tick;
    chk("ring_sticky_osc", 16'(osc_main), 16'h2);
    rst = 1'b1;
    tick;
    chk("ring_rst_osc", 16'(osc_main), 16'h0);
    chk("ring_rst_y",   16'(y_main),   16'h0);
    rst = 1'b0;

    // Inertial delay 3: short glitch discarded, long pulse committed
    tick;
    chk("inr_idle", 16'(y_inr), 16'h0);
    a_inr = 3'b000;
    tick;
    chk("inr_g1_busy", 16'(busy_inr), 16'h1);
    chk("inr_g1_y",    16'(y_inr),    16'h0);
    tick;
    chk("inr_g2_busy", 16'(busy_inr), 16'h1);
    chk("inr_g2_y",    16'(y_inr),    16'h0);
    a_inr = 3'b111;
    tick;
    chk("inr_g3_busy", 16'(busy_inr), 16'h0);
    chk("inr_g3_y",    16'(y_inr),    16'h0);
    tick;
    chk("inr_g4_y", 16'(y_inr), 16'h0);
    a_inr = 3'b000;
    tick;
    chk("inr_p1_y", 16'(y_inr), 16'h0);
    tick;
    chk("inr_p2_y", 16'(y_inr), 16'h0);
    tick;
    chk("inr_p3_y",    16'(y_inr),    16'h1);
    chk("inr_p3_busy", 16'(busy_inr), 16'h0);
    tick;
    chk("inr_p4_busy", 16'(busy_inr), 16'h0);
    chk("inr_p4_y",    16'(y_inr),    16'h1);

    // Reset aborts a pending transition (DELAY 4, IV 1010)
    tick;
    chk("ra_idle_y", 16'(y_rst), 16'ha);
    a_rst = RST_FLIP;
    tick;
    chk("ra_c1_busy", 16'(busy_rst), 16'hf);
    tick;
    chk("ra_c2_busy", 16'(busy_rst), 16'hf);
    chk("ra_c2_y",    16'(y_rst),    16'ha);
    rst   = 1'b1;
    a_rst = RST_STEADY;
    tick;
    chk("ra_rst_y",    16'(y_rst),    16'ha);
    chk("ra_rst_busy", 16'(busy_rst), 16'h0);
    chk("ra_rst_osc",  16'(osc_rst),  16'h0);
    rst = 1'b0;
    tick;
    chk("ra_post_y",    16'(y_rst),    16'ha);
    chk("ra_post_busy", 16'(busy_rst), 16'h0);
    a_rst = RST_FLIP;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("ra_pulse%0d_y", k),    16'(y_rst),    16'ha);
      chk($sformatf("ra_pulse%0d_busy", k), 16'(busy_rst), 16'hf);
    end
    a_rst = RST_STEADY;
    tick;
    chk("ra_end_busy", 16'(busy_rst), 16'h0);
    chk("ra_end_y",    16'(y_rst),    16'ha);

    // Four-cycle pulse is long enough to commit
    a_rst = RST_FLIP;
    tick;
    tick;
    tick;
    chk("ra_long3_y", 16'(y_rst), 16'ha);
    tick;
    chk("ra_long4_y",    16'(y_rst),    16'h5);
    chk("ra_long4_busy", 16'(busy_rst), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
